// File: rtl/fb_swap_controller.sv
// fb_swap_controller: ping-pong frame buffer sequencer for the raycaster display path.
// Gates ray pixel writes into the back buffer and swaps buffers on video frame boundaries.
module fb_swap_controller #(
  parameter int SCREEN_WIDTH   = 320,
  parameter int SCREEN_HEIGHT  = 180,
  parameter int TIMEOUT_FRAMES = 4
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        enable_in,
  input  logic        ray_valid_in,
  input  logic [15:0] ray_address_in,
  input  logic [15:0] ray_pixel_in,
  input  logic        ray_last_pixel_in,
  input  logic        video_last_pixel_in,
  output logic        frame_start_out,
  output logic        wr_sel_out,
  output logic        wr_en1_out,
  output logic        wr_en2_out,
  output logic [15:0] wr_addr_out,
  output logic [15:0] wr_data_out,
  output logic        busy_out,
  output logic [15:0] frame_count_out,
  output logic [7:0]  repeat_count_out,
  output logic        drop_err_out,
  output logic        timeout_out
);
  localparam logic [16:0] PIXELS = 17'(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam logic [3:0]  TMO_LAST = 4'(TIMEOUT_FRAMES - 1);
  typedef enum logic [1:0] {IDLE, RENDER, DONE_WAIT, SWAP} state_t;
  state_t     state;
  logic [3:0] tmo_cnt;
  logic       accept, ray_last;
  assign accept   = state == RENDER && ray_valid_in && {1'b0, ray_address_in} < PIXELS;
  assign ray_last = ray_valid_in && ray_last_pixel_in;
  always_ff @(posedge pixel_clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      frame_start_out  <= 1'b0;
      wr_sel_out       <= 1'b0;
      wr_en1_out       <= 1'b0;
      wr_en2_out       <= 1'b0;
      wr_addr_out      <= '0;
      wr_data_out      <= '0;
      busy_out         <= 1'b0;
      frame_count_out  <= '0;
      repeat_count_out <= '0;
      drop_err_out     <= 1'b0;
      timeout_out      <= 1'b0;
    end else begin
      frame_start_out <= 1'b0;
      wr_en1_out      <= 1'b0;
      wr_en2_out      <= 1'b0;
      if (enable_in && ray_valid_in && !accept) drop_err_out <= 1'b1;
      if (!enable_in) begin
        state    <= IDLE;
        busy_out <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state           <= RENDER;
            busy_out        <= 1'b1;
            frame_start_out <= 1'b1;
          end
          RENDER: begin
            if (accept) begin
              wr_addr_out <= ray_address_in;
              wr_data_out <= ray_pixel_in;
              wr_en1_out  <= !wr_sel_out;
              wr_en2_out  <= wr_sel_out;
            end
            // A finished sweep that coincides with the video frame end skips DONE_WAIT.
            if (ray_last) begin
              state    <= video_last_pixel_in ? SWAP : DONE_WAIT;
              busy_out <= !video_last_pixel_in;
            end else if (video_last_pixel_in) begin
              if (repeat_count_out != 8'hFF) repeat_count_out <= repeat_count_out + 8'd1;
              if (tmo_cnt == TMO_LAST) begin
                timeout_out     <= 1'b1;
                frame_start_out <= 1'b1;
                tmo_cnt         <= '0;
              end else begin
                tmo_cnt <= tmo_cnt + 4'd1;
              end
            end
          end
          DONE_WAIT: if (video_last_pixel_in) begin
            state    <= SWAP;
            busy_out <= 1'b0;
          end
          SWAP: begin
            state           <= RENDER;
            busy_out        <= 1'b1;
            wr_sel_out      <= !wr_sel_out;
            frame_start_out <= 1'b1;
            frame_count_out <= frame_count_out + 16'd1;
            tmo_cnt         <= '0;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_fb_swap_controller.sv
// tb_fb_swap_controller: scoreboard bench; a rule-level reference model queues the
// expected outputs of every clock edge and a monitor compares them after the edge.
module tb_fb_swap_controller;
  localparam int W = 320, H = 180, TMO = 4, PIXELS = W * H;
  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, rv = 1'b0, rl = 1'b0, vl = 1'b0;
  logic [15:0] ra = '0, rd = '0;
  logic        fs, sel, en1, en2, busy, drop, tmo;
  logic [15:0] addr, data, fcnt;
  logic [7:0]  rcnt;
  int checks = 0, errors = 0;
  fb_swap_controller #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .TIMEOUT_FRAMES(TMO)) dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .enable_in(en), .ray_valid_in(rv),
    .ray_address_in(ra), .ray_pixel_in(rd), .ray_last_pixel_in(rl),
    .video_last_pixel_in(vl), .frame_start_out(fs), .wr_sel_out(sel),
    .wr_en1_out(en1), .wr_en2_out(en2), .wr_addr_out(addr), .wr_data_out(data),
    .busy_out(busy), .frame_count_out(fcnt), .repeat_count_out(rcnt),
    .drop_err_out(drop), .timeout_out(tmo));
  always #5 clk = ~clk;
  typedef struct packed {
    bit fs, sel, en1, en2, busy, drop, tmo;
    bit [15:0] addr, data, fcnt;
    bit [7:0] rcnt;
  } exp_t;
  exp_t q[$];
  exp_t m = '0;
  bit running = 0, sweep_done = 0, swap_now = 0;
  int video_frames = 0;
  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask
  // Reference: what the display path should do with this cycle's events.
  task automatic model_step(input bit r, e, v, input bit [15:0] a, d, input bit l, vid);
    bit drawing = running && !sweep_done && !swap_now;
    bit good = drawing && v && int'(a) < PIXELS;
    m.fs = 0; m.en1 = 0; m.en2 = 0;
    if (!r) begin
      m = '0; running = 0; sweep_done = 0; swap_now = 0; video_frames = 0;
      return;
    end
    if (!e) begin
      running = 0; sweep_done = 0; swap_now = 0; m.busy = 0;
      return;
    end
    if (v && !good) m.drop = 1;
    if (!running) begin
      running = 1; m.fs = 1; m.busy = 1;
      return;
    end
    if (swap_now) begin
      swap_now = 0; m.sel = !m.sel; m.fs = 1; m.fcnt++; video_frames = 0; m.busy = 1;
      return;
    end
    if (sweep_done) begin
      if (vid) begin sweep_done = 0; swap_now = 1; m.busy = 0; end
      return;
    end
    if (good) begin
      m.addr = a; m.data = d;
      if (m.sel) m.en2 = 1; else m.en1 = 1;
    end
    if (v && l) begin
      if (vid) begin swap_now = 1; m.busy = 0; end
      else sweep_done = 1;
    end else if (vid) begin
      if (m.rcnt != 8'hFF) m.rcnt++;
      video_frames++;
      if (video_frames == TMO) begin m.tmo = 1; m.fs = 1; video_frames = 0; end
    end
  endtask
  task automatic step(input bit r, e, v, input bit [15:0] a, d, input bit l, vid);
    @(negedge clk);
    rst_n = r; en = e; rv = v; ra = a; rd = d; rl = l; vl = vid;
    model_step(r, e, v, a, d, l, vid);
    q.push_back(m);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 1, 0, 16'h0, 16'h0, 0, 0);
  endtask
  task automatic async_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("async_rst_outs", {fs, sel, en1, en2, busy, drop, tmo}, 0);
    chk("async_rst_cnts", {fcnt, rcnt}, 0);
    chk("async_rst_wr", {addr, data}, 0);
    model_step(0, en, 0, 0, 0, 0, 0);
    q.push_back(m);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("frame_start", fs, e.fs);
        chk("wr_sel", sel, e.sel);
        chk("wr_en1", en1, e.en1);
        chk("wr_en2", en2, e.en2);
        chk("busy", busy, e.busy);
        chk("frame_count", fcnt, e.fcnt);
        chk("repeat_count", rcnt, e.rcnt);
        chk("drop_err", drop, e.drop);
        chk("timeout", tmo, e.tmo);
        if (e.en1 || e.en2) begin
          chk("wr_addr", addr, e.addr);
          chk("wr_data", data, e.data);
        end
      end
    end
  end
  initial begin
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 16'h0010, 16'hF800, 0, 0);
    step(1, 1, 1, 16'h0020, 16'h07E0, 1, 0);
    idle(4);
    step(1, 1, 0, 0, 0, 0, 1);
    idle(2);
    step(1, 1, 1, 16'h0030, 16'h001F, 0, 0);
    step(1, 1, 1, 16'h0040, 16'h1234, 1, 1);
    idle(2);
    step(1, 1, 1, 16'd57600, 16'hAAAA, 0, 0);
    step(1, 1, 1, 16'd57599, 16'h5555, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0, 0, 0, 1);
      idle(2);
    end
    step(1, 1, 1, 16'h0050, 16'h4321, 1, 0);
    idle(2);
    async_reset();
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 16'h0060, 16'hBEEF, 0, 0);
    step(1, 0, 1, 16'h0070, 16'hCAFE, 0, 0);
    step(1, 0, 1, 16'h0080, 16'hCAFE, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit e_r = $urandom_range(0, 99) != 0;
      bit v_r = $urandom_range(0, 1) == 1;
      bit [15:0] a_r = $urandom_range(0, 9) == 0 ? 16'($urandom_range(0, 65535))
                                                 : 16'($urandom_range(0, PIXELS - 1));
      step(1, e_r, v_r, a_r, 16'($urandom), $urandom_range(0, 49) == 0,
           $urandom_range(0, 29) == 0);
    end
    idle(3);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fb_swap_controller.md
Name: fb_swap_controller

Overview:
- Sequences the double-buffered (ping-pong) frame buffer pair used by the raycaster display path.
- Decides which buffer the ray pipeline writes and which the video path reads.
- Gates and registers ray pixel writes, kicks the raycaster at the start of each frame, and swaps buffers only when the back buffer is complete and the video path has finished a frame.
- Sits between the ray flattening stage and the two 320x180 RGB565 BRAMs. Exports status counters for debug/ILA.

Parameters:
- SCREEN_WIDTH, 320, low-resolution frame width in pixels
- SCREEN_HEIGHT, 180, low-resolution frame height in pixels
- TIMEOUT_FRAMES, 4, video frames allowed in RENDER without ray_last_pixel_in before forced restart (1..15)

Ports:
- pixel_clk_in  in  1  pixel clock; all logic on rising edge
- rst_n_in  in  1  asynchronous, active-low reset
- enable_in  in  1  run enable; low returns to IDLE
- ray_valid_in  in  1  ray_address_in/ray_pixel_in valid this cycle
- ray_address_in  in  16  flattened pixel address, 0..SCREEN_WIDTH*SCREEN_HEIGHT-1
- ray_pixel_in  in  16  RGB565 pixel
- ray_last_pixel_in  in  1  final pixel of current ray sweep; qualified by ray_valid_in
- video_last_pixel_in  in  1  one-cycle pulse on last active pixel of a video frame
- frame_start_out  out  1  one-cycle pulse: raycaster begins a new sweep
- wr_sel_out  out  1  0 = write FB1/read FB2; 1 = write FB2/read FB1
- wr_en1_out  out  1  write enable to FB1
- wr_en2_out  out  1  write enable to FB2
- wr_addr_out  out  16  registered write address
- wr_data_out  out  16  registered write data
- busy_out  out  1  high in RENDER or DONE_WAIT
- frame_count_out  out  16  completed swaps, wraps at 2^16
- repeat_count_out  out  8  video frames shown without a new frame, saturates at 255
- drop_err_out  out  1  sticky: write dropped (out of range or outside RENDER)
- timeout_out  out  1  sticky: forced render restart occurred

Behaviour:
- Reset (async assert, sync deassert by caller):
  - State: IDLE.
  - Outputs zero: wr_sel_out, wr_en1_out, wr_en2_out, wr_addr_out, wr_data_out, frame_start_out, busy_out, all counters, all sticky flags.
  - Timeout counter cleared.
- States: IDLE, RENDER, DONE_WAIT, SWAP.
- IDLE:
  - When enable_in=1, go to RENDER and pulse frame_start_out on that edge.
  - wr_sel_out is held.
- RENDER:
  - Accepted write = ray_valid_in && ray_address_in < SCREEN_WIDTH*SCREEN_HEIGHT.
  - 1-cycle latency: next edge registers wr_addr_out/wr_data_out, asserts wr_en1_out if wr_sel_out=0, else wr_en2_out. Never both.
  - Invalid address with ray_valid_in: no write enable; drop_err_out set.
  - ray_valid_in && ray_last_pixel_in, with video_last_pixel_in=0: go to DONE_WAIT. The last pixel is still written (write slot lands one cycle later, before any swap).
  - ray_last_pixel_in and video_last_pixel_in both high in the same cycle: go directly to SWAP.
  - video_last_pixel_in alone: repeat_count_out += 1 (saturating); timeout counter += 1.
  - Timeout counter reaches TIMEOUT_FRAMES: set timeout_out, pulse frame_start_out, clear counter, stay in RENDER with the same wr_sel_out.
- DONE_WAIT:
  - ray_valid_in causes no write; drop_err_out set.
  - video_last_pixel_in: go to SWAP.
- SWAP (exactly one cycle):
  - On the exit edge: toggle wr_sel_out, pulse frame_start_out, frame_count_out += 1, clear timeout counter, go to RENDER.
  - Writes are blocked in SWAP.
- enable_in=0 in any non-IDLE state: next edge goes to IDLE, write enables deassert, no frame_start_out, counters and flags hold.
- Toggle latency: ray_last at cycle N then video_last at cycle M>N gives wr_sel_out toggled visible at M+2. Simultaneous events at cycle N give toggle at N+2.
- busy_out is a registered decode of the state.

Test Plan:
- Reset then enable_in=1 -> frame_start_out high for exactly 1 cycle; wr_sel_out=0; busy_out=1.
- RENDER, addr=0x0010, pixel=0xF800 valid at cycle N -> at N+1: wr_en1_out=1, wr_addr_out=0x0010, wr_data_out=0xF800, wr_en2_out=0.
- ray_last at N, video_last at N+5 -> wr_sel_out=1 and frame_start_out=1 at N+7; frame_count_out=1. Next write asserts wr_en2_out only.
- ray_last and video_last in the same cycle N -> toggle at N+2, no DONE_WAIT. Write to addr 57600 -> no enable, drop_err_out=1.
- 4 video_last pulses with no ray_last -> repeat_count_out=4, timeout_out=1, frame_start_out re-pulses, wr_sel_out unchanged.
- Reset asserted mid-DONE_WAIT -> all outputs 0 immediately (asynchronous). enable_in=0 in RENDER -> IDLE, no write enables.
